btb_predictor_param: RTL

//  Parametrised branch target buffer (BTB) with a per-entry saturating counter. Fully associative.

---
 rtl/btb_predictor_param_if.sv | 28 ++
 rtl/btb_predictor_param.sv | 137 +++++++++++++
 2 files changed

// File: rtl/btb_predictor_param_if.sv
// btb_predictor_param_if: fetch lookup and exec update bundle for the BTB.
// master = fetch/exec side, slave = BTB.
interface btb_predictor_param_if #(
  parameter int ADDR_W = 32
);
  logic              f_req;
  logic [ADDR_W-1:0] f_pc;
  logic              f_hit;
  logic              f_predict_valid;
  logic [ADDR_W-1:0] f_predict_addr;
  logic              x_update;
  logic [ADDR_W-1:0] x_pc;
  logic              x_taken;
  logic [ADDR_W-1:0] x_target;
  logic              flush;

  modport master (
    output f_req, f_pc, x_update, x_pc,
    output x_taken, x_target, flush,
    input  f_hit, f_predict_valid, f_predict_addr
  );

  modport slave (
    input  f_req, f_pc, x_update, x_pc,
    input  x_taken, x_target, flush,
    output f_hit, f_predict_valid, f_predict_addr
  );
endinterface

// File: rtl/btb_predictor_param.sv
// btb_predictor_param: fully associative BTB, saturating counters, RR victim.
// Define BTB_BYPASS_EN to forward a same-edge update to an equal-PC lookup.
module btb_predictor_param #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 8,
  parameter int CTR_W   = 2
) (
  input logic                  clk,
  input logic                  rst,
  btb_predictor_param_if.slave bus
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [CTR_W-1:0] CMAX = '1;
  localparam logic [CTR_W-1:0] WT   = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] WNT  = WT - CTR_W'(1);
  localparam logic [IDX_W-1:0] VLAST = IDX_W'(ENTRIES - 1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]  tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tag_d [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_d [ENTRIES];
  logic [IDX_W-1:0]   vptr_q, vptr_d;

  logic              f_hit_q, f_hit_d;
  logic              f_pv_q, f_pv_d;
  logic [ADDR_W-1:0] f_addr_q, f_addr_d;

  logic             x_hit, f_hit_c;
  logic [IDX_W-1:0] x_idx, f_idx;

  // Tags are unique, so at most one entry matches each PC.
  always_comb begin
    x_hit   = 1'b0;
    x_idx   = '0;
    f_hit_c = 1'b0;
    f_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == bus.x_pc) begin
        x_hit = 1'b1;
        x_idx = IDX_W'(i);
      end
      if (valid_q[i] && tag_q[i] == bus.f_pc) begin
        f_hit_c = 1'b1;
        f_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    vptr_d  = vptr_q;
    if (bus.flush) begin
      valid_d = '0;
      vptr_d  = '0;
    end else if (bus.x_update) begin
      if (x_hit) begin
        if (bus.x_taken) begin
          if (ctr_q[x_idx] != CMAX)
            ctr_d[x_idx] = ctr_q[x_idx] + CTR_W'(1);
          tgt_d[x_idx] = bus.x_target;
        end else if (ctr_q[x_idx] != '0) begin
          ctr_d[x_idx] = ctr_q[x_idx] - CTR_W'(1);
        end
      end else if (bus.x_taken) begin
        valid_d[vptr_q] = 1'b1;
        tag_d[vptr_q]   = bus.x_pc;
        tgt_d[vptr_q]   = bus.x_target;
        ctr_d[vptr_q]   = WT;
        vptr_d = (vptr_q == VLAST) ? '0 : vptr_q + IDX_W'(1);
      end
    end
  end

`ifdef BTB_BYPASS_EN
  logic [IDX_W-1:0] b_idx;
  logic             byp;

  // The post-update entry is either the hit entry or the new allocation.
  always_comb begin
    b_idx = x_hit ? x_idx : vptr_q;
    byp   = bus.f_req && bus.x_update && !bus.flush &&
            (bus.f_pc == bus.x_pc) && (x_hit || bus.x_taken);
  end
`endif

  always_comb begin
    f_hit_d  = 1'b0;
    f_pv_d   = 1'b0;
    f_addr_d = '0;
    if (bus.f_req) begin
      f_hit_d  = f_hit_c;
      f_pv_d   = f_hit_c & ctr_q[f_idx][CTR_W-1];
      f_addr_d = f_hit_c ? tgt_q[f_idx] : '0;
    end
`ifdef BTB_BYPASS_EN
    if (byp) begin
      f_hit_d  = 1'b1;
      f_pv_d   = ctr_d[b_idx][CTR_W-1];
      f_addr_d = tgt_d[b_idx];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      vptr_q   <= '0;
      f_hit_q  <= 1'b0;
      f_pv_q   <= 1'b0;
      f_addr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= WNT;
      end
    end else begin
      valid_q  <= valid_d;
      vptr_q   <= vptr_d;
      f_hit_q  <= f_hit_d;
      f_pv_q   <= f_pv_d;
      f_addr_q <= f_addr_d;
      tag_q    <= tag_d;
      tgt_q    <= tgt_d;
      ctr_q    <= ctr_d;
    end
  end

  assign bus.f_hit           = f_hit_q;
  assign bus.f_predict_valid = f_pv_q;
  assign bus.f_predict_addr  = f_addr_q;
endmodule
